shift_sequencer: RTL and testbench

//  Multi-cycle shift controller. Accepts one shift request over a valid/ready handshake,

---
 rtl/shift_sequencer.sv | 119 +++++++++++
 tb/tb_shift_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA: one log-shifter stage per cycle (2**(SHW-1) down to 1), result after SHW cycles.
// Accepts a request only in IDLE; the result is held in DONE until out_ready, with no queueing of new requests.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0]     OP_SLL = 2'b00;
  localparam logic [1:0]     OP_SRL = 2'b01;
  localparam logic [1:0]     OP_SRA = 2'b10;
  localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        work, work_nxt;
  logic [SHW-1:0]          k, k_nxt;
  logic [SHW-1:0]          shamt_q;
  logic [1:0]              op_q;
  logic                    accept;
  logic [SHW-1:0][WIDTH-1:0] stage_res;
  logic                    stage_en;
  logic [WIDTH-1:0]        stage_sel;

  // Every stage is a fixed-distance shift; only the one selected by k is used each cycle.
  for (genvar i = 0; i < SHW; i++) begin : g_stage
    localparam int AMT = 1 << i;
    assign stage_res[i] =
        (op_q == OP_SLL) ? {work[WIDTH-1-AMT:0], {AMT{1'b0}}} :
        (op_q == OP_SRL) ? {{AMT{1'b0}}, work[WIDTH-1:AMT]} :
        (op_q == OP_SRA) ? {{AMT{work[WIDTH-1]}}, work[WIDTH-1:AMT]} :
                           work;
  end

  always_comb begin
    stage_en  = 1'b0;
    stage_sel = work;
    for (int i = 0; i < SHW; i++) begin
      if (k == SHW'(i)) begin
        stage_en  = shamt_q[i];
        stage_sel = stage_res[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    work_nxt  = work;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          work_nxt  = operandA;
          k_nxt     = K_LAST;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (stage_en) begin
          work_nxt = stage_sel;
        end
        if (k == '0) begin
          state_nxt = DONE;
        end else begin
          k_nxt = k - SHW'(1);
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      k       <= K_LAST;
      work    <= '0;
      shamt_q <= '0;
      op_q    <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      work  <= work_nxt;
      if (accept) begin
        shamt_q <= shamt;
        op_q    <= op;
      end
    end
  end

  // The work register doubles as the result; it holds after the out handshake.
  assign result = work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases, backpressure, mid-shift reset, random traffic.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operandA;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operandA (operandA),
    .shamt    (shamt),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                            input logic [1:0] o);
    case (o)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return $unsigned($signed(a) >>> s);
      default: return a;
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one request, waits for acceptance, then counts cycles until out_valid.
  task automatic issue(input logic [31:0] a, input logic [4:0] s, input logic [1:0] o,
                       input bit rnd_ordy, output int lat, output logic [31:0] res);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    in_valid = 1'b1;
    operandA = a;
    shamt    = s;
    op       = o;
    step();
    in_valid = 1'b0;
    operandA = $urandom;
    shamt    = 5'($urandom);
    op       = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (rnd_ordy) out_ready = 1'($urandom);
      step();
      lat++;
    end
    lat = lat - 1;
    res = result;
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b1;
    operandA  = 32'hFFFF_FFFF;
    shamt     = 5'd3;
    op        = 2'b00;
    out_ready = 1'b0;
    step();
    step();
    reset    = 1'b1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h, want 1 0 0 00000000",
               in_ready, out_valid, busy, result);
    end
  endtask

  task automatic test_directed();
    logic [31:0] a_t [6] = '{32'h8000_0000, 32'h0000_0001, 32'hF000_0000, 32'h7FFF_FFFF,
                             32'hDEAD_BEEF, 32'h1234_5678};
    logic [4:0]  s_t [6] = '{5'd4, 5'd31, 5'd28, 5'd31, 5'd0, 5'd7};
    logic [1:0]  o_t [6] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [31:0] x_t [6] = '{32'hF800_0000, 32'h8000_0000, 32'h0000_000F, 32'h0000_0000,
                             32'hDEAD_BEEF, 32'h1234_5678};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      issue(a_t[i], s_t[i], o_t[i], 1'b0, lat, res);
      total++;
      if (lat !== 5 || res !== x_t[i] || out_valid !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL directed_%0d: latency=%0d result=%h out_valid=%b busy=%b, want 5 %h 1 1",
                 i, lat, res, out_valid, busy, x_t[i]);
      end
      take_out();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== x_t[i]) begin
        bad++;
        $display("FAIL directed_after_%0d: out_valid=%b in_ready=%b busy=%b result=%h, want 0 1 0 %h",
                 i, out_valid, in_ready, busy, result, x_t[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp1 = ref_shift(32'hC001_D00D, 5'd9, 2'b10);
    logic [31:0] exp2 = ref_shift(32'h0F0F_00FF, 5'd13, 2'b00);
    int lat;
    in_valid = 1'b1;
    operandA = 32'hC001_D00D;
    shamt    = 5'd9;
    op       = 2'b10;
    step();
    operandA = 32'h0F0F_00FF;
    shamt    = 5'd13;
    op       = 2'b00;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL bp_shift_%0d: in_ready=%b busy=%b out_valid=%b, want 0 1 0",
                 i, in_ready, busy, out_valid);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || result !== exp1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: out_valid=%b result=%h in_ready=%b, want 1 %h 0",
                 i, out_valid, result, in_ready, exp1);
      end
      if (i < 3) step();
    end
    take_out();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b result=%h, want 0 1 %h",
               out_valid, in_ready, result, exp1);
    end
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    total++;
    if (lat !== 5 || result !== exp2) begin
      bad++;
      $display("FAIL bp_second: latency=%0d result=%h, want 5 %h", lat, result, exp2);
    end
    take_out();
  endtask

  task automatic test_reset_midshift();
    int lat;
    logic [31:0] res;
    in_valid = 1'b1;
    operandA = 32'hFFFF_0000;
    shamt    = 5'd31;
    op       = 2'b01;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL midshift_reset: out_valid=%b in_ready=%b busy=%b result=%h, want 0 1 0 00000000",
               out_valid, in_ready, busy, result);
    end
    issue(32'h0000_00F0, 5'd4, 2'b01, 1'b0, lat, res);
    total++;
    if (lat !== 5 || res !== 32'h0000_000F) begin
      bad++;
      $display("FAIL after_reset_op: latency=%0d result=%h, want 5 0000000f", lat, res);
    end
    take_out();
  endtask

  task automatic test_random();
    int lat;
    int hold;
    logic [31:0] res;
    logic [31:0] a;
    logic [4:0]  s;
    logic [1:0]  o;
    logic [31:0] exp;
    logic        took;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      s = 5'($urandom);
      o = 2'($urandom);
      if (n % 4 == 0) a[31] = 1'b1;
      exp = ref_shift(a, s, o);
      issue(a, s, o, 1'b1, lat, res);
      total++;
      if (lat !== 5 || res !== exp) begin
        bad++;
        $display("FAIL random_%0d: a=%h s=%0d op=%0d latency=%0d result=%h, want 5 %h",
                 n, a, s, o, lat, res, exp);
      end
      hold = 0;
      took = 1'b0;
      while (!took) begin
        out_ready = (hold >= 6) ? 1'b1 : 1'($urandom);
        took = out_ready;
        step();
        hold++;
        if (!took && (out_valid !== 1'b1 || result !== exp)) begin
          total++;
          bad++;
          $display("FAIL random_hold_%0d: out_valid=%b result=%h, want 1 %h",
                   n, out_valid, result, exp);
        end
      end
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL random_release_%0d: out_valid=%b in_ready=%b, want 0 1",
                 n, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midshift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
